seg_scan_display: RTL

- Parametrised, time-multiplexed seven-segment display driver for the board-level debug display.
- Generalises the fixed 4-digit scanner to DIGITS digits, with a programmable refresh prescaler and per-digit decimal points.
- Adds tear-free double-buffered value loading and a freeze control, so the CPU debug value shown via disp_sel never changes mid-frame.

---
 rtl/seg_scan_display.sv | 138 +++++++++++++
 1 files changed

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - time-multiplexed seven-segment scanner with double-buffered value load
// Optional leading-zero blanking: define SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_display #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  load,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  freeze,
    input  logic                  blank,
    output logic [DIGITS-1:0]     disp_anode,
    output logic [7:0]            disp_seg,
    output logic                  digit_tick,
    output logic                  frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_TC    = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   pend_q, pend_d, shad_q, shad_d;
    logic [DIGITS-1:0]     pdp_q, pdp_d, sdp_q, sdp_d;
    logic [DIGITS-1:0]     anode_q, anode_d;
    logic [7:0]            seg_q, seg_d;
    logic                  tick_q, tick_d, frame_q, frame_d;
    logic                  tc, wrap, dp_sel, dark;
    logic [3:0]            nib;
    logic [DIGITS-1:0]     lz;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic                  lz_run;
`endif

    always_comb begin
        tc      = (presc_q == PS_TC);
        wrap    = tc && (idx_q == IDX_LAST);
        presc_d = tc ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (tc) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        tick_d  = tc;
        frame_d = wrap;

        // Load always lands in pending; shadow only moves at a frame boundary, so a coincident load shows one frame later.
        pend_d = load ? value_in : pend_q;
        pdp_d  = load ? dp_in : pdp_q;
        shad_d = (wrap && !freeze) ? pend_q : shad_q;
        sdp_d  = (wrap && !freeze) ? pdp_q : sdp_q;

        lz = '0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        lz_run = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            lz_run = lz_run && (shad_q[4*k +: 4] == 4'h0);
            lz[k]  = lz_run;
        end
`endif

        nib     = '0;
        dp_sel  = 1'b0;
        dark    = blank;
        anode_d = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                nib        = shad_q[4*k +: 4];
                dp_sel     = sdp_q[k];
                anode_d[k] = 1'b0;
                if (lz[k]) begin
                    dark = 1'b1;
                end
            end
        end
        seg_d = {~dp_sel, hex7(nib)};
        if (dark) begin
            anode_d = '1;
            seg_d   = 8'hFF;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            pend_q  <= '0;
            pdp_q   <= '0;
            shad_q  <= '0;
            sdp_q   <= '0;
            anode_q <= '1;
            seg_q   <= 8'hFF;
            tick_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            pdp_q   <= pdp_d;
            shad_q  <= shad_d;
            sdp_q   <= sdp_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
            frame_q <= frame_d;
        end
    end

    assign disp_anode = anode_q;
    assign disp_seg   = seg_q;
    assign digit_tick = tick_q;
    assign frame_done = frame_q;

endmodule
